sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO; next generation of the team's 4x8 FIFO.
- Adds:
  - configurable width and depth
  - correct simultaneous read/write
  - occupancy count output
  - programmable almost-full/almost-empty flags
  - sticky overflow/underflow error flags
  - selectable first-word-fall-through (FWFT) read mode
- Sits between producer/consumer stages that need rate decoupling with early back-pressure.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- DEPTH, 16, number of entries; power of two, >=2.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1).
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write request.
- din  in  DATA_W  write data.
- rd_en  in  1  read request (pop).
- dout  out  DATA_W  read data.
- dout_valid  out  1  dout holds a valid popped/head word.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.
- clr_err  in  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset (rst_n low, async assert, sync-deasserted externally):
  - write/read pointers = 0, count = 0.
  - dout = 0, dout_valid = 0, overflow = 0, underflow = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - Storage array is not reset.
- Reset mid-operation: all contents discarded; first write after release lands at entry 0.
- Acceptance is decided from pre-edge state:
  - wr_acc = wr_en & !full.
  - rd_acc = rd_en & !empty.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Count update:
  - +1 on wr_acc only, -1 on rd_acc only.
  - Unchanged when both are accepted; pointers still both advance.
- Flags are combinational from registered count: zero-cycle lag, no reset-time glitches.
- Full with wr_en & rd_en: read accepted, write rejected, overflow set; count becomes DEPTH-1.
- Empty with wr_en & rd_en:
  - Write accepted, read rejected, underflow set; count becomes 1.
  - No write-to-read bypass, in either mode.
- Standard mode (FWFT=0):
  - On rd_acc, dout <= mem[rd_ptr] at that edge; dout_valid = 1 for exactly that cycle. Read latency is 1 clock.
  - dout holds its last value when no read is accepted.
- FWFT mode (FWFT=1):
  - dout = mem[rd_ptr] combinationally whenever !empty; dout_valid = !empty.
  - rd_en acts as acknowledge/pop; next head appears the cycle after the pop.
  - A word written into an empty FIFO is visible on dout the cycle after the write edge.
- Error flags:
  - overflow set on wr_en & full; underflow set on rd_en & empty.
  - Both held until clr_err or reset. If set and clr_err coincide in one cycle, set wins.
- Rejected operations never modify pointers, count, memory or dout.

Decomposition:
- Package fifo_pkg:
  - ptr_w() helper function returning $clog2(depth).
  - Reset-value constants for the flags.
  - Parameter-legality check used by an elaboration-time assertion (DEPTH power of two, AF/AE ranges).
- One sub-module: fifo_mem_2p, DATA_W x DEPTH array, synchronous write port, asynchronous read port.
- All pointer/count/flag logic stays in sync_fifo_param.

Test Plan:
- Fill/drain (DATA_W=8, DEPTH=16, FWFT=0):
  - Write 0x00..0x0F in 16 cycles -> full=1 and count=16 after 16th edge; almost_full=1 from count=14.
  - Read 16 -> dout 0x00..0x0F, each one cycle after rd_en; empty=1 at end.
- Overflow/underflow:
  - 17th write while full -> rejected, overflow=1, data intact.
  - rd_en while empty -> underflow=1.
  - clr_err pulse -> both flags 0.
- Simultaneous at boundaries:
  - At count=16, wr+rd -> count=15, popped 0x00, written word discarded.
  - At count=0, wr+rd -> count=1, dout_valid=0.
  - At count=5, wr+rd -> count stays 5.
- Wrap-around: 40 interleaved write/read cycles with occupancy 1..3 -> output sequence equals input sequence, no loss across pointer wrap.
- FWFT=1: write 0xA5 into empty -> dout=0xA5, dout_valid=1 next cycle, before any rd_en; rd_en pop -> empty=1, dout_valid=0.
- Async reset: assert rst_n low mid-burst at count=7, between clock edges -> count=0, empty=1, dout_valid=0 immediately; subsequent write/read returns the new data only.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers and constants for the parametrised synchronous FIFO.
// Holds pointer sizing, the legal-parameter check and flag reset values.
package fifo_pkg;

    localparam logic ERR_RST   = 1'b0;
    localparam logic VALID_RST = 1'b0;

    // Pointer width for a power-of-two depth; pointers wrap naturally.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic bit params_ok(input int unsigned data_w,
                                     input int unsigned depth,
                                     input int unsigned af_level,
                                     input int unsigned ae_level);
        return (data_w >= 32'd1) &&
               (depth >= 32'd2) &&
               ((depth & (depth - 32'd1)) == 32'd0) &&
               (af_level >= 32'd1) && (af_level <= depth) &&
               (ae_level <= depth - 32'd1);
    endfunction

endpackage

// File: rtl/sync_fifo_param_mem.sv
// Two-port storage for the FIFO: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module fifo_mem_2p
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [ptr_w(DEPTH)-1:0]    waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [ptr_w(DEPTH)-1:0]    raddr,
    output logic [DATA_W-1:0]          rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost flags, sticky error flags and optional first-word-fall-through.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2,
    parameter bit          FWFT     = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        din,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        dout,
    output logic                     dout_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);

    localparam int unsigned PTR_W = ptr_w(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    if (!params_ok(DATA_W, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
        $error("sync_fifo_param: illegal DATA_W/DEPTH/AF_LEVEL/AE_LEVEL");
    end

    logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [CNT_W-1:0]  count_q, count_nxt;
    logic              overflow_q, underflow_q, overflow_nxt, underflow_nxt;
    logic              wr_acc, rd_acc;
    logic [DATA_W-1:0] rd_data;

    // Flags are decoded from the registered count, so they never lag it.
    assign full         = (count_q == CNT_W'(DEPTH));
    assign empty        = (count_q == CNT_W'(0));
    assign almost_full  = (count_q >= CNT_W'(AF_LEVEL));
    assign almost_empty = (count_q <= CNT_W'(AE_LEVEL));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Acceptance uses pre-edge state: no write-to-read bypass when empty.
    always_comb begin
        wr_acc        = wr_en & ~full;
        rd_acc        = rd_en & ~empty;
        wr_ptr_nxt    = wr_ptr;
        rd_ptr_nxt    = rd_ptr;
        count_nxt     = count_q;
        if (wr_acc) begin
            wr_ptr_nxt = wr_ptr + PTR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_nxt = rd_ptr + PTR_W'(1);
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count_q + CNT_W'(1);
            2'b01:   count_nxt = count_q - CNT_W'(1);
            default: count_nxt = count_q;
        endcase
        // A new error event beats a coincident clear.
        overflow_nxt  = (overflow_q  & ~clr_err) | (wr_en & full);
        underflow_nxt = (underflow_q & ~clr_err) | (rd_en & empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= ERR_RST;
            underflow_q <= ERR_RST;
        end else begin
            wr_ptr      <= wr_ptr_nxt;
            rd_ptr      <= rd_ptr_nxt;
            count_q     <= count_nxt;
            overflow_q  <= overflow_nxt;
            underflow_q <= underflow_nxt;
        end
    end

    fifo_mem_2p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (din),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    if (FWFT) begin : g_fwft
        // Head word is presented directly; rd_en only pops it.
        assign dout       = empty ? '0 : rd_data;
        assign dout_valid = ~empty;
    end else begin : g_std
        logic [DATA_W-1:0] dout_q;
        logic              valid_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_q  <= '0;
                valid_q <= VALID_RST;
            end else begin
                valid_q <= rd_acc;
                if (rd_acc) begin
                    dout_q <= rd_data;
                end
            end
        end

        assign dout       = dout_q;
        assign dout_valid = valid_q;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: a standard-mode 8x16 instance and
// an FWFT 8x4 instance, both compared against queue-based reference models.
module tb_sync_fifo_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Standard-mode instance (DEPTH 16, AF 14, AE 2)
    logic       s_wr = 1'b0, s_rd = 1'b0, s_clr = 1'b0;
    logic [7:0] s_din = '0, s_dout;
    logic       s_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic [4:0] s_count;
    logic [5:0] flags0;
    assign flags0 = {s_full, s_empty, s_af, s_ae, s_ovf, s_unf};

    sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b0)) u_std (
        .clk(clk), .rst_n(rst_n), .wr_en(s_wr), .din(s_din), .rd_en(s_rd),
        .dout(s_dout), .dout_valid(s_valid), .count(s_count), .full(s_full),
        .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
        .overflow(s_ovf), .underflow(s_unf), .clr_err(s_clr));

    // FWFT instance (DEPTH 4, AF 3, AE 1)
    logic       f_wr = 1'b0, f_rd = 1'b0, f_clr = 1'b0;
    logic [7:0] f_din = '0, f_dout;
    logic       f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [2:0] f_count;
    logic [5:0] flags1;
    assign flags1 = {f_full, f_empty, f_af, f_ae, f_ovf, f_unf};

    sync_fifo_param #(.DATA_W(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .wr_en(f_wr), .din(f_din), .rd_en(f_rd),
        .dout(f_dout), .dout_valid(f_valid), .count(f_count), .full(f_full),
        .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
        .overflow(f_ovf), .underflow(f_unf), .clr_err(f_clr));

    // Reference models: contents as queues, sticky flags, last popped word.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic       m_ovf0 = 1'b0, m_unf0 = 1'b0, m_valid0 = 1'b0;
    logic [7:0] m_dout0 = '0;
    logic       m_ovf1 = 1'b0, m_unf1 = 1'b0;

    function automatic logic [5:0] exp_flags0();
        int n = q0.size();
        return {n == 16, n == 0, n >= 14, n <= 2, m_ovf0, m_unf0};
    endfunction

    function automatic logic [5:0] exp_flags1();
        int n = q1.size();
        return {n == 4, n == 0, n >= 3, n <= 1, m_ovf1, m_unf1};
    endfunction

    // One clock on the standard instance; model updated from pre-edge occupancy.
    task automatic cyc0(input logic w, input logic r, input logic [7:0] d, input logic clr);
        int n;
        s_wr = w; s_rd = r; s_din = d; s_clr = clr;
        @(posedge clk);
        n = q0.size();
        m_ovf0 = (m_ovf0 && !clr) || (w && n == 16);
        m_unf0 = (m_unf0 && !clr) || (r && n == 0);
        m_valid0 = 1'b0;
        if (r && n > 0) begin
            m_dout0 = q0.pop_front();
            m_valid0 = 1'b1;
        end
        if (w && n < 16) q0.push_back(d);
        #1;
        s_wr = 1'b0; s_rd = 1'b0; s_clr = 1'b0;
    endtask

    task automatic cyc1(input logic w, input logic r, input logic [7:0] d, input logic clr);
        int n;
        f_wr = w; f_rd = r; f_din = d; f_clr = clr;
        @(posedge clk);
        n = q1.size();
        m_ovf1 = (m_ovf1 && !clr) || (w && n == 4);
        m_unf1 = (m_unf1 && !clr) || (r && n == 0);
        if (r && n > 0) void'(q1.pop_front());
        if (w && n < 4) q1.push_back(d);
        #1;
        f_wr = 1'b0; f_rd = 1'b0; f_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({s_count, flags0} !== {5'd0, 6'b010100}) begin
            errors++;
            $display("FAIL reset_std count=%0d flags=%b required count=0 flags=010100", s_count, flags0);
        end
        checks++;
        if ({s_valid, s_dout} !== 9'd0) begin
            errors++;
            $display("FAIL reset_std_dout valid=%b dout=%h required 0/00", s_valid, s_dout);
        end
        checks++;
        if ({f_count, flags1, f_valid} !== {3'd0, 6'b010100, 1'b0}) begin
            errors++;
            $display("FAIL reset_fwft count=%0d flags=%b valid=%b required 0/010100/0", f_count, flags1, f_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 16; i++) begin
            cyc0(1'b1, 1'b0, 8'(i), 1'b0);
            checks++;
            if ({s_count, flags0} !== {5'(q0.size()), exp_flags0()}) begin
                errors++;
                $display("FAIL fill_state i=%0d count=%0d flags=%b required %0d/%b", i, s_count, flags0, q0.size(), exp_flags0());
            end
        end
        checks++;
        if (s_full !== 1'b1 || s_count !== 5'd16) begin
            errors++;
            $display("FAIL fill_full full=%b count=%0d required 1/16", s_full, s_count);
        end
        for (int i = 0; i < 16; i++) begin
            cyc0(1'b0, 1'b1, 8'h00, 1'b0);
            checks++;
            if (s_valid !== 1'b1 || s_dout !== 8'(i) || {s_count, flags0} !== {5'(q0.size()), exp_flags0()}) begin
                errors++;
                $display("FAIL drain_data i=%0d valid=%b dout=%h count=%0d flags=%b required 1/%h/%0d/%b",
                         i, s_valid, s_dout, s_count, flags0, 8'(i), q0.size(), exp_flags0());
            end
        end
        cyc0(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (s_empty !== 1'b1 || s_valid !== 1'b0 || s_dout !== 8'h0F) begin
            errors++;
            $display("FAIL drain_idle empty=%b valid=%b dout=%h required 1/0/0f", s_empty, s_valid, s_dout);
        end
    endtask

    task automatic test_overflow_underflow();
        for (int i = 0; i < 16; i++) cyc0(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
        cyc0(1'b1, 1'b0, 8'hEE, 1'b0);
        checks++;
        if (s_ovf !== 1'b1 || s_count !== 5'd16 || s_unf !== 1'b0) begin
            errors++;
            $display("FAIL overflow ovf=%b count=%0d unf=%b required 1/16/0", s_ovf, s_count, s_unf);
        end
        for (int i = 0; i < 16; i++) begin
            cyc0(1'b0, 1'b1, 8'h00, 1'b0);
            checks++;
            if (s_dout !== 8'(8'h40 + i) || s_valid !== 1'b1) begin
                errors++;
                $display("FAIL ovf_intact i=%0d dout=%h valid=%b required %h/1", i, s_dout, s_valid, 8'(8'h40 + i));
            end
        end
        cyc0(1'b0, 1'b1, 8'h00, 1'b0);
        checks++;
        if ({s_ovf, s_unf, s_valid, s_count} !== {1'b1, 1'b1, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL underflow ovf=%b unf=%b valid=%b count=%0d required 1/1/0/0", s_ovf, s_unf, s_valid, s_count);
        end
        cyc0(1'b0, 1'b1, 8'h00, 1'b1);
        checks++;
        if ({s_ovf, s_unf} !== 2'b01) begin
            errors++;
            $display("FAIL clr_vs_set ovf=%b unf=%b required 0/1", s_ovf, s_unf);
        end
        cyc0(1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if ({s_ovf, s_unf} !== 2'b00) begin
            errors++;
            $display("FAIL clr_err ovf=%b unf=%b required 0/0", s_ovf, s_unf);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 16; i++) cyc0(1'b1, 1'b0, 8'(i), 1'b0);
        cyc0(1'b1, 1'b1, 8'hFF, 1'b0);
        checks++;
        if ({s_count, s_valid, s_dout, s_ovf} !== {5'd15, 1'b1, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL simul_full count=%0d valid=%b dout=%h ovf=%b required 15/1/00/1", s_count, s_valid, s_dout, s_ovf);
        end
        for (int i = 1; i < 16; i++) begin
            cyc0(1'b0, 1'b1, 8'h00, 1'b0);
            checks++;
            if (s_dout !== 8'(i)) begin
                errors++;
                $display("FAIL simul_full_drain i=%0d dout=%h required %h", i, s_dout, 8'(i));
            end
        end
        cyc0(1'b1, 1'b1, 8'h77, 1'b1);
        checks++;
        if ({s_count, s_valid, s_unf, s_ovf} !== {5'd1, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL simul_empty count=%0d valid=%b unf=%b ovf=%b required 1/0/1/0", s_count, s_valid, s_unf, s_ovf);
        end
        cyc0(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) cyc0(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
        cyc0(1'b1, 1'b1, 8'h99, 1'b0);
        checks++;
        if ({s_count, s_valid, s_dout} !== {5'd5, 1'b1, 8'h77}) begin
            errors++;
            $display("FAIL simul_mid count=%0d valid=%b dout=%h required 5/1/77", s_count, s_valid, s_dout);
        end
        while (q0.size() > 0) begin
            cyc0(1'b0, 1'b1, 8'h00, 1'b0);
            checks++;
            if ({s_valid, s_dout, s_count, flags0} !== {m_valid0, m_dout0, 5'(q0.size()), exp_flags0()}) begin
                errors++;
                $display("FAIL simul_mid_drain valid=%b dout=%h count=%0d required %b/%h/%0d", s_valid, s_dout, s_count, m_valid0, m_dout0, q0.size());
            end
        end
    endtask

    task automatic test_wrap();
        int n;
        logic w, r;
        cyc0(1'b1, 1'b0, 8'($urandom), 1'b0);
        for (int i = 0; i < 40; i++) begin
            n = q0.size();
            w = (n < 3) ? ((n == 1) ? 1'b1 : 1'($urandom)) : 1'b0;
            r = (n == 3) ? 1'b1 : 1'($urandom);
            cyc0(w, r, 8'($urandom), 1'b0);
            checks++;
            if ({s_valid, s_dout, s_count, flags0} !== {m_valid0, m_dout0, 5'(q0.size()), exp_flags0()}) begin
                errors++;
                $display("FAIL wrap i=%0d valid=%b dout=%h count=%0d flags=%b required %b/%h/%0d/%b",
                         i, s_valid, s_dout, s_count, flags0, m_valid0, m_dout0, q0.size(), exp_flags0());
            end
        end
    endtask

    task automatic test_random();
        int bias;
        for (int i = 0; i < 300; i++) begin
            bias = (i % 100 < 50) ? 75 : 25;
            cyc0(1'($urandom_range(0, 99) < bias), 1'($urandom_range(0, 99) >= bias),
                 8'($urandom), 1'($urandom_range(0, 19) == 0));
            checks++;
            if ({s_valid, s_dout, s_count, flags0} !== {m_valid0, m_dout0, 5'(q0.size()), exp_flags0()}) begin
                errors++;
                $display("FAIL random i=%0d valid=%b dout=%h count=%0d flags=%b required %b/%h/%0d/%b",
                         i, s_valid, s_dout, s_count, flags0, m_valid0, m_dout0, q0.size(), exp_flags0());
            end
        end
    endtask

    task automatic test_async_reset();
        while (q0.size() > 0) cyc0(1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 7; i++) cyc0(1'b1, (i == 6), 8'(8'hC0 + i), 1'b0);
        cyc0(1'b1, 1'b0, 8'hC7, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s_count, s_empty, s_valid, s_dout} !== {5'd0, 1'b1, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL async_reset count=%0d empty=%b valid=%b dout=%h required 0/1/0/00", s_count, s_empty, s_valid, s_dout);
        end
        q0.delete();
        m_ovf0 = 1'b0; m_unf0 = 1'b0; m_valid0 = 1'b0; m_dout0 = 8'h00;
        q1.delete();
        m_ovf1 = 1'b0; m_unf1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc0(1'b1, 1'b0, 8'h3C, 1'b0);
        cyc0(1'b1, 1'b0, 8'h5A, 1'b0);
        cyc0(1'b0, 1'b1, 8'h00, 1'b0);
        checks++;
        if ({s_valid, s_dout, s_count} !== {1'b1, 8'h3C, 5'd1}) begin
            errors++;
            $display("FAIL post_reset_rd1 valid=%b dout=%h count=%0d required 1/3c/1", s_valid, s_dout, s_count);
        end
        cyc0(1'b0, 1'b1, 8'h00, 1'b0);
        checks++;
        if ({s_valid, s_dout, s_empty} !== {1'b1, 8'h5A, 1'b1}) begin
            errors++;
            $display("FAIL post_reset_rd2 valid=%b dout=%h empty=%b required 1/5a/1", s_valid, s_dout, s_empty);
        end
    endtask

    task automatic test_fwft();
        cyc1(1'b1, 1'b0, 8'hA5, 1'b0);
        checks++;
        if ({f_valid, f_dout, f_count} !== {1'b1, 8'hA5, 3'd1}) begin
            errors++;
            $display("FAIL fwft_show valid=%b dout=%h count=%0d required 1/a5/1", f_valid, f_dout, f_count);
        end
        cyc1(1'b0, 1'b1, 8'h00, 1'b0);
        checks++;
        if ({f_empty, f_valid} !== 2'b10) begin
            errors++;
            $display("FAIL fwft_pop empty=%b valid=%b required 1/0", f_empty, f_valid);
        end
        cyc1(1'b1, 1'b1, 8'h3E, 1'b0);
        checks++;
        if ({f_valid, f_dout, f_count, f_unf} !== {1'b1, 8'h3E, 3'd1, 1'b1}) begin
            errors++;
            $display("FAIL fwft_simul_empty valid=%b dout=%h count=%0d unf=%b required 1/3e/1/1", f_valid, f_dout, f_count, f_unf);
        end
        for (int i = 0; i < 150; i++) begin
            cyc1(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
                 8'($urandom), 1'($urandom_range(0, 15) == 0));
            checks++;
            if ({f_valid, f_count, flags1} !== {q1.size() > 0, 3'(q1.size()), exp_flags1()} ||
                (q1.size() > 0 && f_dout !== q1[0])) begin
                errors++;
                $display("FAIL fwft_random i=%0d valid=%b dout=%h count=%0d flags=%b required count=%0d flags=%b",
                         i, f_valid, f_dout, f_count, flags1, q1.size(), exp_flags1());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow_underflow();
        test_simultaneous();
        test_wrap();
        test_random();
        test_async_reset();
        test_fwft();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
